// File: rtl/ghost_pkg.sv
// ghost_pkg
// Shared definitions for the ghost sprite indexer slice: the ghost mode
// encoding (also driven out on the mode port), the palette-select codes
// and the sprite edge length in pixels.
package ghost_pkg;

   typedef enum logic [1:0] {
      NORMAL = 2'd0,
      SCARED = 2'd1,
      FLASH  = 2'd2,
      EYES   = 2'd3
   } ghost_mode_t;

   localparam logic [1:0] PAL_NORMAL = 2'b00;
   localparam logic [1:0] PAL_SCARED = 2'b01;
   localparam logic [1:0] PAL_FLASH  = 2'b10;

   localparam int SPRITE_SIZE = 16;

endpackage

// File: rtl/ghost_rom.sv
// ghost_rom
// 16x16 ghost sprite table of 4-bit palette indices with a registered
// (one-cycle) read.
//   i_clk  : system clock
//   i_addr : {row[3:0], column[3:0]}
//   o_data : palette index, valid one cycle after i_addr
// Index meaning: 0 transparent, 1 body, 2 eye white, 3 pupil.
module ghost_rom (
   input  logic       i_clk,
   input  logic [7:0] i_addr,
   output logic [3:0] o_data
);

   logic [63:0] w_row;

   // Each row is written as 16 hex nibbles, leftmost nibble = column 0,
   // so the table reads like the sprite itself.
   always_comb begin
      w_row = 64'h1111_1111_1111_1111;
      case (i_addr[7:4])
         4'd0:    w_row = 64'h0000_0111_1110_0000;
         4'd1:    w_row = 64'h0001_1111_1111_1000;
         4'd2:    w_row = 64'h0011_1111_1111_1100;
         4'd3:    w_row = 64'h0122_2111_1222_2110;
         4'd4:    w_row = 64'h1223_3111_1223_3111;
         4'd5:    w_row = 64'h1222_2111_1222_2111;
         4'd14:   w_row = 64'h1101_1101_1011_1011;
         4'd15:   w_row = 64'h1000_1000_0001_0001;
         default: w_row = 64'h1111_1111_1111_1111;
      endcase
   end

   // Column c sits at bit offset (15-c)*4, which is just ~c shifted by two.
   always_ff @(posedge i_clk) begin
      o_data <= w_row[{~i_addr[3:0], 2'b00} +: 4];
   end

endmodule

// File: rtl/ghost_sprite_indexer.sv
// ghost_sprite_indexer
// Tracks one ghost's behaviour mode and turns the current scan position
// into a palette index for the ghost sprite.
//   Clk, Reset        : system clock, asynchronous active-high reset
//   frame_tick        : one-cycle pulse per video frame
//   DrawX, DrawY      : current pixel coordinates
//   ghost_x, ghost_y  : sprite top-left corner
//   power_pellet      : pulse, scares the ghost (ignored while in EYES)
//   ghost_eaten       : pulse, sends a scared/flashing ghost home as EYES
//   pal_index         : palette index, 0 whenever opaque is 0
//   pal_sel           : 00 normal, 01 scared, 10 flash-white
//   opaque            : current pixel belongs to the ghost
//   mode              : current mode (NORMAL/SCARED/FLASH/EYES)
// Pixel outputs lag DrawX/DrawY by two clocks; mode is undelayed.
// Build option GHOST_FLASH_EN: when defined, SCARED is followed by a
// blinking FLASH period; otherwise SCARED lasts SCARED_FRAMES+FLASH_FRAMES
// frames and returns straight to NORMAL.
module ghost_sprite_indexer
   import ghost_pkg::*;
#(
   parameter int SCARED_FRAMES = 360,
   parameter int FLASH_FRAMES  = 120,
   parameter int FLASH_PERIOD  = 15,
   parameter int EYES_FRAMES   = 90
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_tick,
   input  logic [9:0] DrawX,
   input  logic [9:0] DrawY,
   input  logic [9:0] ghost_x,
   input  logic [9:0] ghost_y,
   input  logic       power_pellet,
   input  logic       ghost_eaten,
   output logic [3:0] pal_index,
   output logic [1:0] pal_sel,
   output logic       opaque,
   output logic [1:0] mode
);

   // The frame counter is 10 bits wide, so every duration must fit in it.
   if (SCARED_FRAMES < 1 || FLASH_FRAMES < 1 || FLASH_PERIOD < 1 || EYES_FRAMES < 1 ||
       SCARED_FRAMES + FLASH_FRAMES > 1024 || EYES_FRAMES > 1024 || FLASH_PERIOD > 1024) begin : g_badParams
      $error("ghost_sprite_indexer: frame parameters out of range");
   end

`ifdef GHOST_FLASH_EN
   localparam logic [9:0]  SCARED_LAST = 10'(SCARED_FRAMES - 1);
   localparam ghost_mode_t SCARED_EXIT = FLASH;
   localparam logic [9:0]  PERIOD_LAST = 10'(FLASH_PERIOD - 1);
`else
   localparam logic [9:0]  SCARED_LAST = 10'(SCARED_FRAMES + FLASH_FRAMES - 1);
   localparam ghost_mode_t SCARED_EXIT = NORMAL;
`endif
   localparam logic [9:0]  FLASH_LAST  = 10'(FLASH_FRAMES - 1);
   localparam logic [9:0]  EYES_LAST   = 10'(EYES_FRAMES - 1);

   ghost_mode_t r_state, w_stateNext;
   logic [9:0]  r_frameCnt, w_frameCntNext;
   logic        w_enter;
   logic [1:0]  w_palSel;

`ifdef GHOST_FLASH_EN
   logic        r_phase, w_phaseNext;
   logic [9:0]  r_flashCnt, w_flashCntNext;
`endif

   // Mode, frame counter and (when enabled) flash phase registers.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state    <= NORMAL;
         r_frameCnt <= '0;
`ifdef GHOST_FLASH_EN
         r_phase    <= 1'b0;
         r_flashCnt <= '0;
`endif
      end else begin
         r_state    <= w_stateNext;
         r_frameCnt <= w_frameCntNext;
`ifdef GHOST_FLASH_EN
         r_phase    <= w_phaseNext;
         r_flashCnt <= w_flashCntNext;
`endif
      end
   end

   // Next-mode logic. ghost_eaten is tested before power_pellet so it wins
   // when both arrive together. A pellet while already SCARED counts as a
   // fresh entry so the counter restarts. Any entry clears the counter.
   always_comb begin
      w_stateNext = r_state;
      w_enter     = 1'b0;
      unique case (r_state)
         NORMAL: begin
            if (power_pellet) begin
               w_stateNext = SCARED;
               w_enter     = 1'b1;
            end
         end
         SCARED: begin
            if (ghost_eaten) begin
               w_stateNext = EYES;
               w_enter     = 1'b1;
            end else if (power_pellet) begin
               w_stateNext = SCARED;
               w_enter     = 1'b1;
            end else if (frame_tick && r_frameCnt == SCARED_LAST) begin
               w_stateNext = SCARED_EXIT;
               w_enter     = 1'b1;
            end
         end
         FLASH: begin
            if (ghost_eaten) begin
               w_stateNext = EYES;
               w_enter     = 1'b1;
            end else if (power_pellet) begin
               w_stateNext = SCARED;
               w_enter     = 1'b1;
            end else if (frame_tick && r_frameCnt == FLASH_LAST) begin
               w_stateNext = NORMAL;
               w_enter     = 1'b1;
            end
         end
         EYES: begin
            if (frame_tick && r_frameCnt == EYES_LAST) begin
               w_stateNext = NORMAL;
               w_enter     = 1'b1;
            end
         end
         default: begin
            w_stateNext = NORMAL;
            w_enter     = 1'b1;
         end
      endcase

      w_frameCntNext = r_frameCnt;
      if (w_enter) begin
         w_frameCntNext = '0;
      end else if (frame_tick) begin
         w_frameCntNext = r_frameCnt + 10'd1;
      end
   end

`ifdef GHOST_FLASH_EN
   // Blink phase: restarts dark (scared colours) on FLASH entry and flips
   // after every FLASH_PERIOD frames spent in FLASH.
   always_comb begin
      w_phaseNext    = r_phase;
      w_flashCntNext = r_flashCnt;
      if (w_enter && w_stateNext == FLASH) begin
         w_phaseNext    = 1'b0;
         w_flashCntNext = '0;
      end else if (r_state == FLASH && frame_tick) begin
         if (r_flashCnt == PERIOD_LAST) begin
            w_flashCntNext = '0;
            w_phaseNext    = ~r_phase;
         end else begin
            w_flashCntNext = r_flashCnt + 10'd1;
         end
      end
   end
`endif

   // Palette select for the current mode, before pipeline alignment.
   always_comb begin
      w_palSel = PAL_NORMAL;
      case (r_state)
         SCARED: w_palSel = PAL_SCARED;
`ifdef GHOST_FLASH_EN
         FLASH:  w_palSel = r_phase ? PAL_FLASH : PAL_SCARED;
`else
         FLASH:  w_palSel = PAL_SCARED;
`endif
         default: w_palSel = PAL_NORMAL;
      endcase
   end

   // Hit test. Offsets are unsigned 10-bit differences, so a pixel left of
   // or above the sprite wraps to a large value and misses.
   logic [9:0] w_dx, w_dy;
   logic       w_hit;
   assign w_dx  = DrawX - ghost_x;
   assign w_dy  = DrawY - ghost_y;
   assign w_hit = (w_dx < 10'(SPRITE_SIZE)) && (w_dy < 10'(SPRITE_SIZE));

   logic       r_hit1, r_hit2;
   logic [7:0] r_addr;
   logic [1:0] r_palSel1, r_palSel2;
   logic       r_eyes1, r_eyes2;
   logic [3:0] w_romData;

   // Two-stage pixel pipeline. Stage 1 holds the hit flag and ROM address;
   // stage 2 lines up with the ROM's registered data. The mode-derived
   // palette select and EYES flag travel alongside to stay aligned.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_hit1    <= 1'b0;
         r_hit2    <= 1'b0;
         r_addr    <= '0;
         r_palSel1 <= PAL_NORMAL;
         r_palSel2 <= PAL_NORMAL;
         r_eyes1   <= 1'b0;
         r_eyes2   <= 1'b0;
      end else begin
         r_hit1    <= w_hit;
         r_addr    <= {w_dy[3:0], w_dx[3:0]};
         r_hit2    <= r_hit1;
         r_palSel1 <= w_palSel;
         r_palSel2 <= r_palSel1;
         r_eyes1   <= (r_state == EYES);
         r_eyes2   <= r_eyes1;
      end
   end

   ghost_rom u_rom (
      .i_clk  (Clk),
      .i_addr (r_addr),
      .o_data (w_romData)
   );

   // In EYES only the eye whites and pupils are drawn; the body vanishes.
   logic w_idxOk;
   assign w_idxOk   = (w_romData != 4'd0) &&
                      (!r_eyes2 || w_romData == 4'd2 || w_romData == 4'd3);
   assign opaque    = r_hit2 && w_idxOk;
   assign pal_index = opaque ? w_romData : 4'd0;
   assign pal_sel   = r_palSel2;
   assign mode      = r_state;

endmodule

// File: tb/tb_ghost_sprite_indexer.sv
// tb_ghost_sprite_indexer
// Directed bench for ghost_sprite_indexer with hand-computed expectations.
// Expectations for the mode timeline follow GHOST_FLASH_EN.
module tb_ghost_sprite_indexer;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       frame_tick = 1'b0;
   logic [9:0] DrawX = '0;
   logic [9:0] DrawY = '0;
   logic [9:0] ghost_x = '0;
   logic [9:0] ghost_y = '0;
   logic       power_pellet = 1'b0;
   logic       ghost_eaten = 1'b0;
   logic [3:0] pal_index;
   logic [1:0] pal_sel;
   logic       opaque;
   logic [1:0] mode;

   int totalCount = 0;
   int passCount  = 0;
   int failCount  = 0;

   // Sprite row 0 columns 0..15 plus one column past the edge.
   logic [3:0] rowZero [17] = '{0,0,0,0,0,1,1,1,1,1,1,0,0,0,0,0,0};
   // Sprite row 4 as drawn in EYES: body (1) pixels disappear.
   logic [3:0] eyesRow4 [16] = '{0,2,2,3,3,0,0,0,0,2,2,3,3,0,0,0};

   logic seenFlash;
   logic seenWhite;

   ghost_sprite_indexer dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .frame_tick   (frame_tick),
      .DrawX        (DrawX),
      .DrawY        (DrawY),
      .ghost_x      (ghost_x),
      .ghost_y      (ghost_y),
      .power_pellet (power_pellet),
      .ghost_eaten  (ghost_eaten),
      .pal_index    (pal_index),
      .pal_sel      (pal_sel),
      .opaque       (opaque),
      .mode         (mode)
   );

   always #5 Clk = ~Clk;

   // Advance n rising edges, then settle 1 time unit past the edge.
   task automatic applyStimulus(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      totalCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // One frame pulse followed by an idle cycle.
   task automatic frameTick(input int n);
      for (int k = 0; k < n; k++) begin
         frame_tick = 1'b1;
         applyStimulus(1);
         frame_tick = 1'b0;
         applyStimulus(1);
      end
   endtask

   task automatic pulsePellet();
      power_pellet = 1'b1;
      applyStimulus(1);
      power_pellet = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Reset held with every pulse active and a hit pixel presented.
      ghost_x = 10'd100; ghost_y = 10'd50;
      DrawX = 10'd105; DrawY = 10'd50;
      power_pellet = 1'b1; ghost_eaten = 1'b1; frame_tick = 1'b1;
      applyStimulus(3);
      checkOutput("reset_mode", mode, 0);
      checkOutput("reset_opaque", opaque, 0);
      checkOutput("reset_pal_index", pal_index, 0);
      checkOutput("reset_pal_sel", pal_sel, 0);

      power_pellet = 1'b0; ghost_eaten = 1'b0; frame_tick = 1'b0;
      DrawX = 10'd0; Reset = 1'b0;
      applyStimulus(1);
      checkOutput("release_mode", mode, 0);

      // Scan row 0 across the sprite and one pixel past it.
      $display("[TB] row 0 scan");
      for (int i = 0; i <= 17; i++) begin
         DrawX = 10'(100 + i);
         applyStimulus(1);
         if (i >= 1) begin
            checkOutput($sformatf("row0_opaque_dx%0d", i - 1), opaque, (rowZero[i-1] != 4'd0));
            checkOutput($sformatf("row0_index_dx%0d", i - 1), pal_index, rowZero[i-1]);
         end
      end
      checkOutput("normal_pal_sel", pal_sel, 0);

      // Underflow to the left wraps and misses; in-range and dy=16 cases.
      ghost_x = 10'd5; DrawX = 10'd2; DrawY = 10'd50;
      applyStimulus(2);
      checkOutput("underflow_opaque", opaque, 0);
      checkOutput("underflow_index", pal_index, 0);
      DrawX = 10'd10;
      applyStimulus(2);
      checkOutput("dx5_opaque", opaque, 1);
      checkOutput("dx5_index", pal_index, 1);
      DrawY = 10'd66;
      applyStimulus(2);
      checkOutput("dy16_opaque", opaque, 0);

      // ghost_eaten outside SCARED/FLASH does nothing.
      ghost_eaten = 1'b1;
      applyStimulus(1);
      ghost_eaten = 1'b0;
      checkOutput("eaten_in_normal", mode, 0);

      // Park the scan on a body pixel so pal_sel is visible.
      ghost_x = 10'd100; DrawX = 10'd105; DrawY = 10'd50;
      pulsePellet();
      checkOutput("pellet_to_scared", mode, 1);
      applyStimulus(2);
      checkOutput("scared_pal_sel", pal_sel, 1);
      checkOutput("scared_opaque", opaque, 1);

`ifdef GHOST_FLASH_EN
      $display("[TB] flash timeline");
      frameTick(359);
      checkOutput("scared_tick359", mode, 1);
      frameTick(1);
      checkOutput("flash_entry", mode, 2);
      applyStimulus(2);
      checkOutput("flash_phase0", pal_sel, 1);
      frameTick(14);
      applyStimulus(2);
      checkOutput("flash_tick14", pal_sel, 1);
      frameTick(1);
      applyStimulus(2);
      checkOutput("flash_tick15", pal_sel, 2);
      frameTick(104);
      checkOutput("flash_tick119", mode, 2);
      frameTick(1);
      checkOutput("flash_to_normal", mode, 0);

      pulsePellet();
      frameTick(360);
      checkOutput("flash_again", mode, 2);
      frameTick(50);
      pulsePellet();
      checkOutput("flash_pellet_mode", mode, 1);
      applyStimulus(2);
      checkOutput("flash_pellet_pal_sel", pal_sel, 1);
      frameTick(359);
      checkOutput("rescared_tick359", mode, 1);
      frameTick(1);
      checkOutput("rescared_tick360", mode, 2);
`else
      $display("[TB] scared timeline without flash");
      frameTick(200);
      pulsePellet();
      checkOutput("rescared_mode", mode, 1);
      seenFlash = 1'b0;
      seenWhite = 1'b0;
      for (int t = 0; t < 479; t++) begin
         frameTick(1);
         if (mode == 2'd2) seenFlash = 1'b1;
         if (pal_sel == 2'b10) seenWhite = 1'b1;
      end
      checkOutput("scared_tick479", mode, 1);
      frameTick(1);
      checkOutput("scared_tick480", mode, 0);
      checkOutput("no_flash_mode", seenFlash, 0);
      checkOutput("no_flash_pal_sel", seenWhite, 0);
`endif

      // Eaten and pellet together while scared: eaten wins.
      pulsePellet();
      checkOutput("scared_for_eyes", mode, 1);
      frameTick(10);
      ghost_eaten = 1'b1; power_pellet = 1'b1;
      applyStimulus(1);
      ghost_eaten = 1'b0; power_pellet = 1'b0;
      checkOutput("eaten_wins", mode, 3);
      pulsePellet();
      checkOutput("pellet_in_eyes", mode, 3);

      $display("[TB] eyes row 4 scan");
      DrawY = 10'd54;
      for (int i = 0; i <= 16; i++) begin
         DrawX = 10'(100 + i);
         applyStimulus(1);
         if (i >= 1) begin
            checkOutput($sformatf("eyes_opaque_dx%0d", i - 1), opaque, (eyesRow4[i-1] != 4'd0));
            checkOutput($sformatf("eyes_index_dx%0d", i - 1), pal_index, eyesRow4[i-1]);
         end
      end
      checkOutput("eyes_pal_sel", pal_sel, 0);
      frameTick(89);
      checkOutput("eyes_tick89", mode, 3);
      frameTick(1);
      checkOutput("eyes_to_normal", mode, 0);

      // Reset mid-SCARED with a hit pixel in flight.
      DrawX = 10'd105; DrawY = 10'd50;
      pulsePellet();
      frameTick(5);
      checkOutput("pre_reset_mode", mode, 1);
      checkOutput("pre_reset_opaque", opaque, 1);
      DrawX = 10'd106;
      Reset = 1'b1;
      #1;
      checkOutput("async_reset_opaque", opaque, 0);
      checkOutput("async_reset_mode", mode, 0);
      checkOutput("async_reset_pal_sel", pal_sel, 0);
      applyStimulus(1);
      DrawX = 10'd300;
      Reset = 1'b0;
      applyStimulus(1);
      checkOutput("post_reset_opaque1", opaque, 0);
      applyStimulus(1);
      checkOutput("post_reset_opaque2", opaque, 0);
      frameTick(1);
      checkOutput("post_reset_mode", mode, 0);

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule

// File: doc/ghost_sprite_indexer.md
GHOST_SPRITE_INDEXER -- requirements
Module: ghost_sprite_indexer

Interface
REQ-001 SHALL have parameter SCARED_FRAMES, default 360, frames spent in SCARED before FLASH.
REQ-002 SHALL have parameter FLASH_FRAMES, default 120, frames spent in FLASH before NORMAL.
REQ-003 SHALL have parameter FLASH_PERIOD, default 15, frames per flash half-period.
REQ-004 SHALL have parameter EYES_FRAMES, default 90, frames spent in EYES before NORMAL.
REQ-005 SHALL have port Clk, input, 1 bit: the single system clock.
REQ-006 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port frame_tick, input, 1 bit: one-cycle pulse, once per video frame.
REQ-008 SHALL have ports DrawX and DrawY, input, 10 bits each: current pixel coordinates.
REQ-009 SHALL have ports ghost_x and ghost_y, input, 10 bits each: sprite top-left position.
REQ-010 SHALL have port power_pellet, input, 1 bit: one-cycle pulse when Pac-Man eats a power pellet.
REQ-011 SHALL have port ghost_eaten, input, 1 bit: one-cycle pulse when Pac-Man eats this ghost.
REQ-012 SHALL have port pal_index, output, 4 bits: index sent to the palette lookup.
REQ-013 SHALL have port pal_sel, output, 2 bits: palette select (00 normal, 01 scared, 10 flash-white).
REQ-014 SHALL have port opaque, output, 1 bit: the current pixel is drawn by the ghost.
REQ-015 SHALL have port mode, output, 2 bits: current FSM state.

Function
REQ-016 FSM SHALL have states NORMAL=0, SCARED=1, FLASH=2 and EYES=3, encoded on mode.
REQ-017 A 10-bit frame counter SHALL clear on every state entry and increment on each frame_tick.
REQ-018 power_pellet in NORMAL, SCARED or FLASH SHALL move the FSM to SCARED next cycle and clear the counter.
REQ-019 power_pellet in EYES SHALL be ignored.
REQ-020 ghost_eaten in SCARED or FLASH SHALL move the FSM to EYES; ghost_eaten in NORMAL or EYES SHALL be ignored.
REQ-021 If ghost_eaten and power_pellet arrive in the same cycle in SCARED or FLASH, ghost_eaten SHALL win.
REQ-022 On a frame_tick at counter == SCARED_FRAMES-1, SCARED SHALL move to FLASH.
REQ-023 On a frame_tick at counter == FLASH_FRAMES-1, FLASH SHALL move to NORMAL.
REQ-024 On a frame_tick at counter == EYES_FRAMES-1, EYES SHALL move to NORMAL.
REQ-025 A flash phase bit SHALL clear on FLASH entry and toggle every FLASH_PERIOD frame_ticks.
REQ-026 pal_sel SHALL be 00 in NORMAL and EYES, 01 in SCARED, and in FLASH 01 when phase=0, 10 when phase=1.
REQ-027 Hit test: dx = DrawX - ghost_x and dy = DrawY - ghost_y, as unsigned 10-bit differences; the pixel SHALL hit when dx < 16 and dy < 16, so wrap-around negative offsets miss.
REQ-028 ROM address SHALL be {dy[3:0], dx[3:0]}, addressing a 256-entry table of 4-bit indices.
REQ-029 Pipeline: hit and address SHALL be registered in stage 1 and the ROM data registered in stage 2, giving pal_index, opaque and pal_sel valid 2 cycles after DrawX/DrawY.
REQ-030 opaque SHALL be set when stage-2 hit=1 and the index is nonzero; in EYES it SHALL additionally require an index of 2 or 3.
REQ-031 pal_index SHALL be 0 whenever opaque is 0.
REQ-032 pal_sel SHALL be delayed 2 cycles so that it stays aligned with pal_index.

Reset
REQ-033 While Reset=1, the FSM SHALL be NORMAL, counter=0, phase=0, pipeline hit=0, pal_index=0, pal_sel=00, opaque=0 and mode=00.
REQ-034 Reset asserted mid-SCARED or mid-pipeline SHALL discard all state, with no residual opaque pixel after release.
REQ-035 Reset SHALL take priority over all input pulses in the same cycle.

Configuration
REQ-036 Macro GHOST_FLASH_EN defined: SHALL provide the FLASH state and phase toggling as specified above.
REQ-037 Macro GHOST_FLASH_EN undefined: SCARED SHALL last SCARED_FRAMES+FLASH_FRAMES frames and then go directly to NORMAL; pal_sel SHALL never be 10; the phase logic SHALL be absent.

Structure
REQ-038 The shared package ghost_pkg SHALL hold the ghost_mode_t enum, the pal_sel encodings and the SPRITE_SIZE=16 constant.
REQ-039 The sprite table SHALL be a sub-module, ghost_rom, with a synchronous 1-cycle read: 8-bit address in, 4-bit data out.

Verification
REQ-040 Reset release, ghost at (100,50), scan DrawX=100..115 on DrawY=50 -> opaque follows ROM row 0 with 2-cycle latency; DrawX=116 -> opaque=0 two cycles later.
REQ-041 ghost_x=5, DrawX=2 (underflow) -> opaque=0.
REQ-042 power_pellet, then 360 frame_ticks -> mode=1 through tick 359, then mode=2; after 15 more ticks pal_sel=10; after 120 ticks in FLASH, mode=0.
REQ-043 power_pellet at FLASH tick 50 -> mode=1, counter=0, pal_sel=01.
REQ-044 ghost_eaten and power_pellet in the same cycle in SCARED -> mode=3; then only index 2/3 pixels are opaque; after 90 ticks -> mode=0.
REQ-045 Reset pulse mid-SCARED with a hit in flight -> opaque=0 and mode=0 immediately; with GHOST_FLASH_EN undefined, 480 ticks after power_pellet -> mode=0 with no mode=2 seen.
